// File: rtl/ex_result_skid_pkg.sv
// Shared types and constants for the execute-stage result skid buffer.
// The beat struct is the unit stored in both the main and skid registers.
package ex_result_skid_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              taken;
    logic              illegal;
  } ex_beat_t;

endpackage

// File: rtl/ex_result_skid_br_cond_eval.sv
// Combinational branch resolver: ALU flags from a SUB plus funct3 -> taken/illegal.
// Non-branch beats always resolve not-taken and legal.
module br_cond_eval
  import ex_result_skid_pkg::*;
(
  input  logic       is_branch,
  input  logic [2:0] funct3,
  input  logic       neg,
  input  logic       ovf,
  input  logic       zero,
  input  logic       carry,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (is_branch) begin
      case (funct3)
        BR_BEQ:  taken = zero;
        BR_BNE:  taken = !zero;
        BR_BLT:  taken = neg ^ ovf;
        BR_BGE:  taken = !(neg ^ ovf);
        // carry means borrow on SUB, i.e. A <u B
        BR_BLTU: taken = carry;
        BR_BGEU: taken = !carry;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ex_result_skid.sv
// Execute-stage result buffer: 2-entry skid between ALU and MEM, with branch
// resolution at accept and a one-cycle redirect pulse for taken branches.
module ex_result_skid
  import ex_result_skid_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_result,
  input  logic              in_neg,
  input  logic              in_ovf,
  input  logic              in_zero,
  input  logic              in_carry,
  input  logic              in_is_branch,
  input  logic [2:0]        in_br_funct3,
  input  logic [XLEN-1:0]   in_target,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_taken,
  output logic              out_br_illegal,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  ex_beat_t        main_q, main_d, skid_q, skid_d, beat_in;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            br_taken, br_illegal;
  logic            accept, xfer;

  br_cond_eval u_br_cond_eval (
    .is_branch (in_is_branch),
    .funct3    (in_br_funct3),
    .neg       (in_neg),
    .ovf       (in_ovf),
    .zero      (in_zero),
    .carry     (in_carry),
    .taken     (br_taken),
    .illegal   (br_illegal)
  );

  // in_ready comes straight from a flop so MEM stalls never reach the ALU path
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready && !flush;
  assign xfer     = main_valid_q && out_ready;

  always_comb begin
    beat_in.result    = in_result;
    beat_in.rd        = in_rd;
    beat_in.reg_write = in_reg_write && !in_is_branch;
    beat_in.taken     = br_taken;
    beat_in.illegal   = br_illegal;
  end

  always_comb begin
    main_d        = main_q;
    skid_d        = skid_q;
    main_valid_d  = main_valid_q;
    skid_valid_d  = skid_valid_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (accept && beat_in.taken) begin
        redir_valid_d = 1'b1;
        redir_pc_d    = in_target;
      end
      if (!main_valid_q || xfer) begin
        // main frees up: oldest held beat (skid) moves forward first
        if (skid_valid_q) begin
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = accept;
          if (accept) skid_d = beat_in;
        end else begin
          main_valid_d = accept;
          if (accept) main_d = beat_in;
        end
      end else if (accept) begin
        skid_d       = beat_in;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q        <= '0;
      skid_q        <= '0;
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      main_q        <= main_d;
      skid_q        <= skid_d;
      main_valid_q  <= main_valid_d;
      skid_valid_q  <= skid_valid_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign out_valid      = main_valid_q;
  assign out_result     = main_q.result;
  assign out_rd         = main_q.rd;
  assign out_reg_write  = main_q.reg_write;
  assign out_taken      = main_q.taken;
  assign out_br_illegal = main_q.illegal;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;

endmodule
